// File: rtl/novacore_pio_in_capture.sv
// novacore_pio_in_capture: Avalon-MM input PIO with input synchronizer, sticky edge capture and masked level irq.
// Driver note: the previous-sample register resets to 0, so an input held high through reset
// is reported as a rising-edge capture once the synchronizer has filled.
module novacore_pio_in_capture #(
    parameter int               WIDTH       = 8,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mux;
    logic             w_wr;
    logic             w_unused;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_prev;
    assign w_fall   = ~w_sync_q & r_prev;
    assign w_edge   = (EDGE_TYPE == 0) ? w_rise : (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);
    assign w_wr     = chipselect & ~write_n;
    assign w_wdata  = writedata[WIDTH-1:0];
    assign w_clr    = (w_wr && address == 2'd3) ? w_wdata : '0;
    assign w_mux    = (address == 2'd0) ? w_sync_q :
                      (address == 2'd2) ? r_mask :
                      (address == 2'd3) ? r_cap : '0;
    assign w_unused = ^writedata;

    // Input synchronizer; its last stage is the data register seen at address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    // Edge history, sticky capture where a new edge beats a same-cycle clear, and the irq mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_cap  <= '0;
            r_mask <= RESET_MASK;
        end else begin
            r_prev <= w_sync_q;
            r_cap  <= w_edge | (r_cap & ~w_clr);
            if (w_wr && address == 2'd2) r_mask <= w_wdata;
        end
    end

    // Fixed one-cycle read latency and registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= 32'(w_mux);
            irq      <= |(r_cap & r_mask);
        end
    end
endmodule

// File: tb/tb_novacore_pio_in_capture.sv
// tb_novacore_pio_in_capture: three edge-mode instances driven in parallel and checked against a behavioural model.
module tb_novacore_pio_in_capture;
    localparam int SS = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [7:0]       in_port = '0;
    logic [2:0][31:0] rd;
    logic [2:0]       irq_v;

    int n_checks = 0;
    int n_fail = 0;
    bit en = 0;

    always #5 clk = ~clk;

    novacore_pio_in_capture #(.EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_v[0]));
    novacore_pio_in_capture #(.EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_v[1]));
    novacore_pio_in_capture #(.EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_v[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    // Behavioural model: input history queue, edge rules per mode, sticky capture, mask, 1-cycle read/irq.
    logic [7:0]  hist[$];
    logic [7:0]  m_prev, sq, rise, fall, eg, clr;
    logic [7:0]  m_cap [3];
    logic [7:0]  m_mask [3];
    logic [31:0] m_rd [3];
    logic        m_irq [3];
    bit          m_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist = '{};
            for (int j = 0; j < SS; j++) hist.push_back(8'h00);
            m_prev = 8'h00;
            for (int k = 0; k < 3; k++) begin
                m_cap[k] = 8'h00;
                m_mask[k] = 8'h00;
                m_rd[k] = 32'h0;
                m_irq[k] = 1'b0;
            end
        end else begin
            sq = hist[SS-1];
            rise = sq & ~m_prev;
            fall = ~sq & m_prev;
            m_wr = chipselect && !write_n;
            clr = (m_wr && address == 2'd3) ? writedata[7:0] : 8'h00;
            for (int k = 0; k < 3; k++) begin
                eg = (k == 0) ? rise : (k == 1) ? fall : (rise | fall);
                m_rd[k] = {24'h0, (address == 2'd0) ? sq : (address == 2'd2) ? m_mask[k] :
                                  (address == 2'd3) ? m_cap[k] : 8'h00};
                m_irq[k] = |(m_cap[k] & m_mask[k]);
                m_cap[k] = eg | (m_cap[k] & ~clr);
                if (m_wr && address == 2'd2) m_mask[k] = writedata[7:0];
            end
            m_prev = sq;
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_readdata[%0d]", k), rd[k], m_rd[k]);
                check($sformatf("model_irq[%0d]", k), {31'h0, irq_v[k]}, {31'h0, m_irq[k]});
            end
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        en = 1;
        cyc(3);
        check("reset_irq", {29'h0, irq_v}, 32'h0);
        check("reset_rd", rd[0], 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            cyc(1);
            check($sformatf("idle_read_a%0d", a), rd[0], 32'h0);
        end
        address = 2'd0;
        in_port = 8'hA5;
        cyc(1);
        check("latency_n", rd[0], 32'h0);
        cyc(1);
        check("latency_n1", rd[0], 32'h0);
        cyc(1);
        check("latency_n2", rd[0], 32'hA5);
        in_port = 8'h00;
        cyc(4);
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        address = 2'd3;
        in_port = 8'h03;
        cyc(3);
        check("irq_before_cap", {31'h0, irq_v[0]}, 32'h0);
        in_port = 8'h02;
        cyc(1);
        check("irq_after_cap", {31'h0, irq_v[0]}, 32'h1);
        check("rise_cap", rd[0], 32'h03);
        cyc(2);
        in_port = 8'h03;
        cyc(2);
        wr(2'd3, 32'h03);
        cyc(1);
        check("w1c_collide_cap", rd[0], 32'h01);
        check("w1c_collide_irq", {31'h0, irq_v[0]}, 32'h1);
        wr(2'd3, 32'h01);
        check("irq_before_clear", {31'h0, irq_v[0]}, 32'h1);
        cyc(1);
        check("cap_cleared", rd[0], 32'h0);
        check("irq_cleared", {31'h0, irq_v[0]}, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h07;
        cyc(3);
        in_port = 8'h03;
        cyc(1);
        check("any_on_rise", rd[2], 32'h04);
        check("fall_not_on_rise", rd[1], 32'h0);
        check("rise_bit2", rd[0], 32'h04);
        cyc(2);
        check("fall_pending", rd[1], 32'h0);
        cyc(1);
        check("fall_on_fall", rd[1], 32'h04);
        check("any_sticky", rd[2], 32'h04);
        wr(2'd2, 32'h80);
        in_port = 8'h83;
        cyc(5);
        check("irq_bit7", {31'h0, irq_v[0]}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_irq", {29'h0, irq_v}, 32'h0);
        check("async_rd", rd[0], 32'h0);
        cyc(2);
        reset_n = 1'b1;
        address = 2'd2;
        cyc(1);
        check("mask_reset", rd[0], 32'h0);
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            chipselect = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 3) != 0);
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
